// File: rtl/ex_operand_stage_if.sv
// Bundle between decode/forwarding sources, the ID->EX operand stage and the ALU.
// The master side drives decode fields, forwarding results and out_ready; the slave is the stage.
interface ex_operand_stage_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_pc;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic [XLEN-1:0]       in_imm;
    logic [3:0]            in_alu_ctrl;
    logic                  in_op1_sel;
    logic                  in_op2_sel;
    logic                  in_word;
    logic                  in_reg_we;
    logic                  fwd_ex_we;
    logic [REG_ADDR_W-1:0] fwd_ex_rd;
    logic [XLEN-1:0]       fwd_ex_data;
    logic                  fwd_wb_we;
    logic [REG_ADDR_W-1:0] fwd_wb_rd;
    logic [XLEN-1:0]       fwd_wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [3:0]            alu_ctrl;
    logic [XLEN-1:0]       out_rs2_data;
    logic [XLEN-1:0]       out_pc;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_reg_we;
    logic                  out_word;

    modport master (
        output flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
               in_rd_addr, in_imm, in_alu_ctrl, in_op1_sel, in_op2_sel, in_word, in_reg_we,
               fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data, out_ready,
        input  in_ready, out_valid, op1, op2, alu_ctrl, out_rs2_data, out_pc, out_rd_addr,
               out_reg_we, out_word
    );

    modport slave (
        input  flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
               in_rd_addr, in_imm, in_alu_ctrl, in_op1_sel, in_op2_sel, in_word, in_reg_we,
               fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data, out_ready,
        output in_ready, out_valid, op1, op2, alu_ctrl, out_rs2_data, out_pc, out_rd_addr,
               out_reg_we, out_word
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID->EX stage: holds one decoded instruction, forwards EX/MEM and MEM/WB results into its
// source operands and conditions the ALU operands (PC/imm select, RV64 *W shift handling).
module ex_operand_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input logic              clk,
    input logic              rst_n,
    ex_operand_stage_if.slave bus
);
    localparam logic [3:0] ALU_SLL = 4'h8;
    localparam logic [3:0] ALU_SRL = 4'h9;
    localparam logic [3:0] ALU_SRA = 4'hA;

    logic                  held_valid;
    logic [XLEN-1:0]       held_pc;
    logic [XLEN-1:0]       held_rs1_data;
    logic [XLEN-1:0]       held_rs2_data;
    logic [REG_ADDR_W-1:0] held_rs1_addr;
    logic [REG_ADDR_W-1:0] held_rs2_addr;
    logic [REG_ADDR_W-1:0] held_rd_addr;
    logic [XLEN-1:0]       held_imm;
    logic [3:0]            held_alu_ctrl;
    logic                  held_op1_sel;
    logic                  held_op2_sel;
    logic                  held_word;
    logic                  held_reg_we;

    logic                  accept;
    logic [XLEN-1:0]       fwd_rs1;
    logic [XLEN-1:0]       fwd_rs2;
    logic [XLEN-1:0]       op1_raw;
    logic [XLEN-1:0]       op2_raw;
    logic                  is_shift;

    // Handshake: a transfer happens on any rising edge where in_valid & in_ready; out_valid
    // marks held data for the ALU and is retired on an edge where out_ready is high.
    assign bus.in_ready = !held_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // EX/MEM is the younger producer so it has priority; x0 is hard-wired and never forwards.
    always_comb begin
        fwd_rs1 = held_rs1_data;
        if (held_rs1_addr != '0) begin
            if (bus.fwd_ex_we && bus.fwd_ex_rd == held_rs1_addr)
                fwd_rs1 = bus.fwd_ex_data;
            else if (bus.fwd_wb_we && bus.fwd_wb_rd == held_rs1_addr)
                fwd_rs1 = bus.fwd_wb_data;
        end
    end

    always_comb begin
        fwd_rs2 = held_rs2_data;
        if (held_rs2_addr != '0) begin
            if (bus.fwd_ex_we && bus.fwd_ex_rd == held_rs2_addr)
                fwd_rs2 = bus.fwd_ex_data;
            else if (bus.fwd_wb_we && bus.fwd_wb_rd == held_rs2_addr)
                fwd_rs2 = bus.fwd_wb_data;
        end
    end

    assign op1_raw  = held_op1_sel ? held_pc  : fwd_rs1;
    assign op2_raw  = held_op2_sel ? held_imm : fwd_rs2;
    assign is_shift = (held_alu_ctrl == ALU_SLL) || (held_alu_ctrl == ALU_SRL) ||
                      (held_alu_ctrl == ALU_SRA);

    // *W right shifts must see only the low word; the 32-bit result is sign-extended later.
    always_comb begin
        bus.op1 = op1_raw;
        if (held_word && held_alu_ctrl == ALU_SRL)
            bus.op1 = {{(XLEN-32){1'b0}}, op1_raw[31:0]};
        else if (held_word && held_alu_ctrl == ALU_SRA)
            bus.op1 = {{(XLEN-32){op1_raw[31]}}, op1_raw[31:0]};
    end

    always_comb begin
        bus.op2 = op2_raw;
        if (is_shift) begin
            if (held_word)
                bus.op2 = {{(XLEN-5){1'b0}}, op2_raw[4:0]};
            else
                bus.op2 = {{(XLEN-6){1'b0}}, op2_raw[5:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_valid    <= 1'b0;
            held_pc       <= '0;
            held_rs1_data <= '0;
            held_rs2_data <= '0;
            held_rs1_addr <= '0;
            held_rs2_addr <= '0;
            held_rd_addr  <= '0;
            held_imm      <= '0;
            held_alu_ctrl <= '0;
            held_op1_sel  <= 1'b0;
            held_op2_sel  <= 1'b0;
            held_word     <= 1'b0;
            held_reg_we   <= 1'b0;
        end else if (bus.flush) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid    <= 1'b1;
            held_pc       <= bus.in_pc;
            held_rs1_data <= bus.in_rs1_data;
            held_rs2_data <= bus.in_rs2_data;
            held_rs1_addr <= bus.in_rs1_addr;
            held_rs2_addr <= bus.in_rs2_addr;
            held_rd_addr  <= bus.in_rd_addr;
            held_imm      <= bus.in_imm;
            held_alu_ctrl <= bus.in_alu_ctrl;
            held_op1_sel  <= bus.in_op1_sel;
            held_op2_sel  <= bus.in_op2_sel;
            held_word     <= bus.in_word;
            held_reg_we   <= bus.in_reg_we;
        end else if (bus.out_ready) begin
            held_valid <= 1'b0;
        end else if (held_valid) begin
            // Stalled: capture forwarded values so a producer leaving WB is not lost.
            held_rs1_data <= fwd_rs1;
            held_rs2_data <= fwd_rs2;
        end
    end

    assign bus.out_valid    = held_valid;
    assign bus.alu_ctrl     = held_alu_ctrl;
    assign bus.out_rs2_data = fwd_rs2;
    assign bus.out_pc       = held_pc;
    assign bus.out_rd_addr  = held_rd_addr;
    assign bus.out_reg_we   = held_reg_we && held_valid;
    assign bus.out_word     = held_word;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios followed by random traffic, all outputs
// compared every cycle against an instruction-level reference model.
module tb_ex_operand_stage;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ex_operand_stage_if b ();

    ex_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently held by the stage.
    logic        m_valid;
    logic [63:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1a, m_rs2a, m_rd;
    logic [3:0]  m_ctrl;
    logic        m_s1, m_s2, m_word, m_we;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fwd(input logic [4:0] a, input logic [63:0] held);
        if (a == 0) return held;
        if (b.fwd_ex_we && b.fwd_ex_rd == a) return b.fwd_ex_data;
        if (b.fwd_wb_we && b.fwd_wb_rd == a) return b.fwd_wb_data;
        return held;
    endfunction

    function automatic logic [63:0] exp_op1();
        logic [63:0] base;
        logic [63:0] lo;
        base = m_s1 ? m_pc : fwd(m_rs1a, m_rs1d);
        lo   = base % 64'h1_0000_0000;
        if (m_word && m_ctrl == 4'd9) return lo;
        if (m_word && m_ctrl == 4'd10) return (lo >= 64'h8000_0000) ? lo - 64'h1_0000_0000 : lo;
        return base;
    endfunction

    function automatic logic [63:0] exp_op2();
        logic [63:0] base;
        base = m_s2 ? m_imm : fwd(m_rs2a, m_rs2d);
        if (m_ctrl >= 4'd8 && m_ctrl <= 4'd10) return m_word ? base % 32 : base % 64;
        return base;
    endfunction

    task automatic check_model();
        chk("out_valid", 64'(b.out_valid), 64'(m_valid));
        chk("in_ready", 64'(b.in_ready), 64'(!m_valid || b.out_ready));
        chk("op1", b.op1, exp_op1());
        chk("op2", b.op2, exp_op2());
        chk("alu_ctrl", 64'(b.alu_ctrl), 64'(m_ctrl));
        chk("out_rs2_data", b.out_rs2_data, fwd(m_rs2a, m_rs2d));
        chk("out_pc", b.out_pc, m_pc);
        chk("out_rd_addr", 64'(b.out_rd_addr), 64'(m_rd));
        chk("out_reg_we", 64'(b.out_reg_we), 64'(m_we && m_valid));
        chk("out_word", 64'(b.out_word), 64'(m_word));
    endtask

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
        m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_ctrl = 0;
        m_s1 = 0; m_s2 = 0; m_word = 0; m_we = 0;
    endtask

    // Advance the model by one clock using the inputs presently driven.
    task automatic model_step();
        logic [63:0] f1, f2;
        f1 = fwd(m_rs1a, m_rs1d);
        f2 = fwd(m_rs2a, m_rs2d);
        if (!rst_n) begin
            model_reset();
        end else if (b.flush) begin
            m_valid = 0;
        end else if (b.in_valid && (!m_valid || b.out_ready)) begin
            m_valid = 1; m_pc = b.in_pc; m_rs1d = b.in_rs1_data; m_rs2d = b.in_rs2_data;
            m_rs1a = b.in_rs1_addr; m_rs2a = b.in_rs2_addr; m_rd = b.in_rd_addr;
            m_imm = b.in_imm; m_ctrl = b.in_alu_ctrl; m_s1 = b.in_op1_sel;
            m_s2 = b.in_op2_sel; m_word = b.in_word; m_we = b.in_reg_we;
        end else if (b.out_ready) begin
            m_valid = 0;
        end else if (m_valid) begin
            m_rs1d = f1;
            m_rs2d = f2;
        end
    endtask

    // Inputs are driven just after a falling edge; check, model, then cross the rising edge.
    task automatic tick();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_instr(input logic [63:0] pc, input logic [4:0] rs1a, input logic [63:0] rs1d,
                               input logic [4:0] rs2a, input logic [63:0] rs2d, input logic [4:0] rd,
                               input logic [63:0] imm, input logic [3:0] ctrl, input logic s1,
                               input logic s2, input logic word, input logic we);
        b.in_valid = 1; b.in_pc = pc; b.in_rs1_addr = rs1a; b.in_rs1_data = rs1d;
        b.in_rs2_addr = rs2a; b.in_rs2_data = rs2d; b.in_rd_addr = rd; b.in_imm = imm;
        b.in_alu_ctrl = ctrl; b.in_op1_sel = s1; b.in_op2_sel = s2; b.in_word = word;
        b.in_reg_we = we;
    endtask

    task automatic fwd_off();
        b.fwd_ex_we = 0; b.fwd_ex_rd = 0; b.fwd_ex_data = 0;
        b.fwd_wb_we = 0; b.fwd_wb_rd = 0; b.fwd_wb_data = 0;
    endtask

    function automatic logic [63:0] rand64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    task automatic rand_inputs();
        rst_n = ($urandom_range(0, 49) != 0);
        b.flush = ($urandom_range(0, 9) == 0);
        b.out_ready = ($urandom_range(0, 2) != 0);
        drive_instr(rand64(), 5'($urandom_range(0, 7)), rand64(), 5'($urandom_range(0, 7)),
                    rand64(), 5'($urandom_range(0, 31)), rand64(), 4'($urandom_range(0, 10)),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        b.in_valid = ($urandom_range(0, 3) != 0);
        b.fwd_ex_we = 1'($urandom); b.fwd_ex_rd = 5'($urandom_range(0, 7)); b.fwd_ex_data = rand64();
        b.fwd_wb_we = 1'($urandom); b.fwd_wb_rd = 5'($urandom_range(0, 7)); b.fwd_wb_data = rand64();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 0;
        b.flush = 0;
        b.out_ready = 0;
        drive_instr(64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 4'd0, 0, 0, 0, 0);
        b.in_valid = 0;
        fwd_off();
        model_reset();

        // Reset held for two clocks.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        b.out_ready = 1;
        #1;
        chk("rst_out_valid", 64'(b.out_valid), 64'd0);
        chk("rst_in_ready", 64'(b.in_ready), 64'd1);
        chk("rst_op1", b.op1, 64'd0);
        chk("rst_op2", b.op2, 64'd0);
        chk("rst_reg_we", 64'(b.out_reg_we), 64'd0);

        // ADD, no hazard.
        drive_instr(64'h100, 5'd1, 64'd10, 5'd2, 64'd15, 5'd4, 64'd0, 4'd0, 0, 0, 0, 1);
        tick();
        b.in_valid = 0;
        #1;
        chk("add_op1", b.op1, 64'd10);
        chk("add_op2", b.op2, 64'd15);
        chk("add_ctrl", 64'(b.alu_ctrl), 64'd0);
        chk("add_valid", 64'(b.out_valid), 64'd1);

        // Forward priority, then x0 never forwards.
        drive_instr(64'h104, 5'd3, 64'd1, 5'd2, 64'd2, 5'd6, 64'd0, 4'd0, 0, 0, 0, 1);
        tick();
        b.in_valid = 0; b.out_ready = 0;
        b.fwd_ex_we = 1; b.fwd_ex_rd = 5'd3; b.fwd_ex_data = 64'd7;
        b.fwd_wb_we = 1; b.fwd_wb_rd = 5'd3; b.fwd_wb_data = 64'd9;
        #1;
        chk("fwd_ex_wins", b.op1, 64'd7);
        b.fwd_ex_we = 0;
        #1;
        chk("fwd_wb", b.op1, 64'd9);
        fwd_off();
        b.out_ready = 1;
        tick();
        drive_instr(64'h108, 5'd0, 64'h1234, 5'd2, 64'd2, 5'd6, 64'd0, 4'd0, 0, 0, 0, 1);
        tick();
        b.in_valid = 0;
        b.fwd_ex_we = 1; b.fwd_ex_rd = 5'd0; b.fwd_ex_data = 64'd7;
        b.fwd_wb_we = 1; b.fwd_wb_rd = 5'd0; b.fwd_wb_data = 64'd9;
        #1;
        chk("x0_no_fwd", b.op1, 64'h1234);
        fwd_off();

        // Stall refresh: a WB producer visible for one stalled cycle only.
        drive_instr(64'h10c, 5'd1, 64'd1, 5'd5, 64'h11, 5'd7, 64'd0, 4'd0, 0, 0, 0, 1);
        tick();
        drive_instr(64'h110, 5'd1, 64'd1, 5'd6, 64'h66, 5'd8, 64'd0, 4'd0, 0, 0, 0, 1);
        b.out_ready = 0;
        b.fwd_wb_we = 1; b.fwd_wb_rd = 5'd5; b.fwd_wb_data = 64'h55;
        #1;
        chk("stall1_in_ready", 64'(b.in_ready), 64'd0);
        tick();
        fwd_off();
        #1;
        chk("stall2_op2", b.op2, 64'h55);
        chk("stall2_in_ready", 64'(b.in_ready), 64'd0);
        tick();
        #1;
        chk("stall3_op2", b.op2, 64'h55);
        chk("stall3_in_ready", 64'(b.in_ready), 64'd0);
        tick();
        b.out_ready = 1;
        tick();
        b.in_valid = 0;
        #1;
        chk("after_stall_op2", b.op2, 64'h66);
        chk("after_stall_pc", b.out_pc, 64'h110);

        // SRAW with immediate shift amount, then non-word SLL.
        drive_instr(64'h114, 5'd7, 64'h0000_0000_8000_0010, 5'd0, 64'd0, 5'd9, 64'h24, 4'hA, 0, 1, 1, 1);
        tick();
        b.in_valid = 0;
        #1;
        chk("sraw_op1", b.op1, 64'hFFFF_FFFF_8000_0010);
        chk("sraw_op2", b.op2, 64'd4);
        drive_instr(64'h118, 5'd7, 64'h3, 5'd0, 64'd0, 5'd9, 64'h44, 4'h8, 0, 1, 0, 1);
        tick();
        b.in_valid = 0;
        #1;
        chk("sll_op2", b.op2, 64'd4);

        // Flush kills both held and incoming instruction.
        drive_instr(64'h11c, 5'd1, 64'd1, 5'd2, 64'd2, 5'd3, 64'd0, 4'd0, 0, 0, 0, 1);
        b.flush = 1;
        tick();
        b.flush = 0; b.in_valid = 0;
        #1;
        chk("flush_valid", 64'(b.out_valid), 64'd0);
        chk("flush_reg_we", 64'(b.out_reg_we), 64'd0);

        // Back-to-back accepts with no bubbles.
        for (int i = 0; i < 4; i++) begin
            drive_instr(64'h200 + 64'(4 * i), 5'd1, 64'(i), 5'd2, 64'(i + 1), 5'(i + 1),
                        64'd0, 4'd1, 0, 0, 0, 1);
            tick();
            chk("b2b_valid", 64'(b.out_valid), 64'd1);
            chk("b2b_pc", b.out_pc, 64'h200 + 64'(4 * i));
        end

        // Random traffic including stalls, flushes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
